// File: rtl/stochastic_sampler.sv
// stochastic_sampler
//   Bernoulli sampling stage for RBM unit activations. Accepts NUM_UNITS
//   activation probabilities over a valid/ready handshake, compares each one
//   against the free-running random word on rand_in in its accept cycle, and
//   packs the resulting unit states into one vector offered downstream with
//   a valid/ready handshake.
//
//   Optional feature macro: SAMPLER_ONES_CNT_EN
//     defined   -> adds output ones_cnt, the number of 1 bits in vec_out
//     undefined -> port and counter absent, all other behaviour identical
//
// Ports
//   clk        in   1          clock, all logic on posedge
//   reset      in   1          synchronous reset, active-high
//   start      in   1          begins a new vector (honoured only in IDLE)
//   prob_in    in   bitlength  activation probability, P(1) = prob_in / 2**bitlength
//   prob_valid in   1          prob_in valid
//   prob_ready out  1          sampler can accept prob_in (high in SAMPLE)
//   rand_in    in   bitlength  random word from RandomGenerator
//   vec_out    out  NUM_UNITS  sampled unit states, bit i = unit i
//   vec_valid  out  1          vec_out complete and stable (high in DONE)
//   vec_ready  in   1          consumer accepts vec_out
//   busy       out  1          high in SAMPLE or DONE
//   ones_cnt   out  CNT_W+1    popcount of vec_out (SAMPLER_ONES_CNT_EN only)

module stochastic_sampler #(
    parameter int unsigned bitlength = 8,
    parameter int unsigned NUM_UNITS = 16,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [bitlength-1:0] prob_in,
    input  logic                 prob_valid,
    output logic                 prob_ready,
    input  logic [bitlength-1:0] rand_in,
    output logic [NUM_UNITS-1:0] vec_out,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic                 busy
`ifdef SAMPLER_ONES_CNT_EN
    ,
    output logic [CNT_W:0]       ones_cnt
`endif
);

    localparam int unsigned OC_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_UNITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;

    // Handshake and Bernoulli decision for the current unit.
    logic accept_c;
    logic sample_bit_c;

    assign accept_c     = prob_valid & prob_ready;
    assign sample_bit_c = (rand_in < prob_in);

    // FSM with registered outputs; flags are set alongside the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            vec_out    <= '0;
            prob_ready <= 1'b0;
            vec_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef SAMPLER_ONES_CNT_EN
            ones_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SAMPLE;
                        idx        <= '0;
                        vec_out    <= '0;
                        prob_ready <= 1'b1;
                        busy       <= 1'b1;
`ifdef SAMPLER_ONES_CNT_EN
                        ones_cnt   <= '0;
`endif
                    end
                end

                SAMPLE: begin
                    if (accept_c) begin
                        // Write only the bit addressed by idx; decode keeps
                        // indexing in range for any NUM_UNITS.
                        for (int i = 0; i < NUM_UNITS; i++) begin
                            if (idx == CNT_W'(i)) begin
                                vec_out[i] <= sample_bit_c;
                            end
                        end
`ifdef SAMPLER_ONES_CNT_EN
                        ones_cnt <= ones_cnt + OC_W'(sample_bit_c);
`endif
                        if (idx == LAST_IDX) begin
                            state      <= DONE;
                            idx        <= '0;
                            prob_ready <= 1'b0;
                            vec_valid  <= 1'b1;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end

                DONE: begin
                    // start is deliberately ignored here, even alongside vec_ready.
                    if (vec_ready) begin
                        state     <= IDLE;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    idx        <= '0;
                    prob_ready <= 1'b0;
                    vec_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stochastic_sampler.sv
// Self-checking bench for stochastic_sampler: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_stochastic_sampler;

    localparam int unsigned BL = 8;
    localparam int unsigned NU = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BL-1:0] prob_in;
    logic          prob_valid;
    logic          prob_ready;
    logic [BL-1:0] rand_in;
    logic [NU-1:0] vec_out;
    logic          vec_valid;
    logic          vec_ready;
    logic          busy;
`ifdef SAMPLER_ONES_CNT_EN
    logic [CW:0]   ones_cnt;
`endif

    stochastic_sampler #(.bitlength(BL), .NUM_UNITS(NU), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prob_in    (prob_in),
        .prob_valid (prob_valid),
        .prob_ready (prob_ready),
        .rand_in    (rand_in),
        .vec_out    (vec_out),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .busy       (busy)
`ifdef SAMPLER_ONES_CNT_EN
        ,
        .ones_cnt   (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 collecting units, 2 vector offered.
    int          m_phase = 0;
    int          m_units = 0;
    logic [NU-1:0] m_vec = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check outputs.
    task automatic cyc(input logic rs, input logic st, input logic pv,
                       input logic [BL-1:0] pr, input logic [BL-1:0] rn, input logic vr);
        reset = rs; start = st; prob_valid = pv; prob_in = pr; rand_in = rn; vec_ready = vr;
        if (rs) begin
            m_phase = 0; m_units = 0; m_vec = '0;
        end else if (m_phase == 0) begin
            if (st) begin m_phase = 1; m_units = 0; m_vec = '0; end
        end else if (m_phase == 1) begin
            if (pv) begin
                m_vec[m_units] = (int'(rn) < int'(pr));
                m_units++;
                if (m_units == NU) begin m_phase = 2; m_units = 0; end
            end
        end else begin
            if (vr) m_phase = 0;
        end
        @(posedge clk);
        #1;
        check("vec_out", 32'(vec_out), 32'(m_vec));
        check("flags", {29'd0, prob_ready, vec_valid, busy},
              {29'd0, m_phase == 1, m_phase == 2, m_phase != 0});
`ifdef SAMPLER_ONES_CNT_EN
        if (m_phase == 2) check("ones_cnt", 32'(ones_cnt), 32'($countones(m_vec)));
`endif
    endtask

    logic [BL-1:0] lfsr;
    logic [BL-1:0] r;
    int            stat_ones;
    int            stat_ok;

    initial begin
        reset = 1'b1; start = 1'b0; prob_valid = 1'b0; prob_in = '0; rand_in = '0; vec_ready = 1'b0;

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 8'hFF, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset mid-SAMPLE at idx 5 discards the partial vector.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'hFF, 8'h10, 0);
        cyc(1, 0, 1, 8'hFF, 8'h10, 0);
        check("rst_mid_vec", 32'(vec_out), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);

        // Saturation: all ones, then all zeros.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < NU; i++) cyc(0, 0, 1, 8'hFF, 8'h3C, 0);
        check("sat_ff", 32'(vec_out), 32'h0000_FFFF);
        check("sat_ff_valid", 32'(vec_valid), 32'h1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < NU; i++) cyc(0, 0, 1, 8'h00, 8'h00, 0);
        check("sat_00", 32'(vec_out), 32'h0);
        cyc(0, 0, 0, 0, 0, 1);

        // FF boundary: all-ones random word yields 0.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < NU; i++) cyc(0, 0, 1, 8'hFF, (i == 3) ? 8'hFF : 8'hFE, 0);
        check("ff_vs_ff", 32'(vec_out), 32'h0000_FFF7);
        cyc(0, 0, 0, 0, 0, 1);

        // Alternating FF/00 starting at unit 0.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < NU; i++) begin
            r = 8'($urandom_range(0, 254));
            cyc(0, 0, 1, (i % 2 == 0) ? 8'hFF : 8'h00, r, 0);
        end
        check("alt_5555", 32'(vec_out), 32'h0000_5555);
`ifdef SAMPLER_ONES_CNT_EN
        check("alt_ones", 32'(ones_cnt), 32'd8);
`endif
        cyc(0, 0, 0, 0, 0, 1);

        // Backpressure on both sides: 16 accepts over 31 cycles, then 10 stalled DONE cycles.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * NU - 1; i++) begin
            r = 8'($urandom);
            cyc(0, 0, (i % 2 == 0), 8'($urandom), r, 0);
        end
        check("bp_done", 32'(vec_valid), 32'h1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'($urandom), 8'($urandom), 0);
        cyc(0, 0, 0, 0, 0, 1);

        // start during SAMPLE at idx 7 is ignored; start with vec_ready in DONE does not restart.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'h80, 8'($urandom), 0);
        cyc(0, 1, 0, 8'h80, 8'h00, 0);
        for (int i = 7; i < NU; i++) cyc(0, 0, 1, 8'h80, 8'($urandom), 0);
        check("mid_start_done", 32'(vec_valid), 32'h1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("done_start_idle", 32'(busy), 32'h0);

        // Statistical: LFSR random words, p = 0x40/256, 4096 samples.
        lfsr = 8'hA5;
        stat_ones = 0;
        for (int v = 0; v < 4096 / NU; v++) begin
            cyc(0, 1, 0, 0, 0, 0);
            for (int i = 0; i < NU; i++) begin
                cyc(0, 0, 1, 8'h40, lfsr, 0);
                lfsr = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
            end
            stat_ones += $countones(vec_out);
            cyc(0, 0, 0, 0, 0, 1);
        end
        stat_ok = (stat_ones >= 901 && stat_ones <= 1146) ? 1 : 0;
        check("stat_frac", 32'(stat_ok), 32'h1);

        // Random traffic on every input, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
